dmem_access_arbiter: RTL

- Two-port arbiter/sequencer in front of the single-port DataMemory block RAM (clka/wea/addra/dina/douta).
- Shares the memory between the CPU load/store unit (port C) and the debug/program-loader port (port D).
- Issues one access at a time, enforces the RAM read latency, and returns read data with a valid pulse.
- Rejects out-of-range word addresses.

---
 rtl/dmem_access_arbiter.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/dmem_access_arbiter.sv
// Two-port (core/debug) arbiter and sequencer in front of the single-port DataMemory RAM.
// Serialises accesses, range-checks word addresses and returns load data with a valid pulse.
module dmem_access_arbiter #(
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned RD_LAT     = 1,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [3:0]  c_be,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic        c_gnt,
  output logic        c_err,
  output logic        c_rvalid,
  output logic [31:0] c_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_err,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [30:0] DEPTH_W = 31'(DEPTH);

  state_t      state, state_n;
  logic        last_d, last_d_n;
  logic        sel_d, sel_d_n;
  logic        is_load, is_load_n;
  logic        ok, ok_n;
  logic [2:0]  cnt, cnt_n;

  logic        c_gnt_n, c_err_n, c_rvalid_n;
  logic        d_gnt_n, d_err_n, d_rvalid_n;
  logic [31:0] c_rdata_n, d_rdata_n;
  logic [3:0]  mem_we_n;
  logic [31:0] mem_addr_n, mem_din_n;
  logic        busy_n;

  logic        pick_d;
  logic        w_we;
  logic [3:0]  w_be;
  logic [29:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_in_range;

  logic        unused_addr_bits;
  assign unused_addr_bits = ^{c_addr[1:0], d_addr[1:0]};

  // D wins only when C is idle, or on a tie when round-robin says C went last.
  assign pick_d     = d_req && (!c_req || (!FIXED_PRIO && !last_d));
  assign w_we       = pick_d ? d_we    : c_we;
  assign w_be       = pick_d ? d_be    : c_be;
  assign w_addr     = pick_d ? d_addr[31:2] : c_addr[31:2];
  assign w_wdata    = pick_d ? d_wdata : c_wdata;
  assign w_in_range = {1'b0, w_addr} < DEPTH_W;

  // Outputs are computed one state ahead so every port comes straight from a flop.
  always_comb begin
    state_n    = state;
    last_d_n   = last_d;
    sel_d_n    = sel_d;
    is_load_n  = is_load;
    ok_n       = ok;
    cnt_n      = cnt;
    c_gnt_n    = 1'b0;
    c_err_n    = 1'b0;
    c_rvalid_n = 1'b0;
    d_gnt_n    = 1'b0;
    d_err_n    = 1'b0;
    d_rvalid_n = 1'b0;
    c_rdata_n  = c_rdata;
    d_rdata_n  = d_rdata;
    mem_we_n   = '0;
    mem_addr_n = mem_addr;
    mem_din_n  = mem_din;
    unique case (state)
      IDLE: begin
        if (c_req || d_req) begin
          state_n   = ISSUE;
          sel_d_n   = pick_d;
          last_d_n  = pick_d;
          is_load_n = !w_we;
          ok_n      = w_in_range;
          c_gnt_n   = !pick_d;
          d_gnt_n   = pick_d;
          c_err_n   = !pick_d && !w_in_range;
          d_err_n   = pick_d && !w_in_range;
          if (w_in_range) begin
            mem_addr_n = {2'b00, w_addr};
            if (w_we) begin
              mem_we_n  = w_be;
              mem_din_n = w_wdata;
            end
          end
        end
      end
      ISSUE: begin
        if (!is_load) begin
          state_n = IDLE;
        end else if (!ok || RD_LAT <= 1) begin
          state_n = RESP;
        end else begin
          state_n = WAIT;
          cnt_n   = 3'(RD_LAT - 2);
        end
      end
      WAIT: begin
        if (cnt == '0) state_n = RESP;
        else           cnt_n   = cnt - 3'd1;
      end
      RESP: begin
        state_n = IDLE;
        if (ok) begin
          if (sel_d) begin
            d_rvalid_n = 1'b1;
            d_rdata_n  = mem_dout;
          end else begin
            c_rvalid_n = 1'b1;
            c_rdata_n  = mem_dout;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last_d   <= 1'b1;
      sel_d    <= 1'b0;
      is_load  <= 1'b0;
      ok       <= 1'b0;
      cnt      <= '0;
      c_gnt    <= 1'b0;
      c_err    <= 1'b0;
      c_rvalid <= 1'b0;
      c_rdata  <= '0;
      d_gnt    <= 1'b0;
      d_err    <= 1'b0;
      d_rvalid <= 1'b0;
      d_rdata  <= '0;
      mem_we   <= '0;
      mem_addr <= '0;
      mem_din  <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      last_d   <= last_d_n;
      sel_d    <= sel_d_n;
      is_load  <= is_load_n;
      ok       <= ok_n;
      cnt      <= cnt_n;
      c_gnt    <= c_gnt_n;
      c_err    <= c_err_n;
      c_rvalid <= c_rvalid_n;
      c_rdata  <= c_rdata_n;
      d_gnt    <= d_gnt_n;
      d_err    <= d_err_n;
      d_rvalid <= d_rvalid_n;
      d_rdata  <= d_rdata_n;
      mem_we   <= mem_we_n;
      mem_addr <= mem_addr_n;
      mem_din  <= mem_din_n;
      busy     <= busy_n;
    end
  end

endmodule
